bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Two-master arbiter placed in front of mmapper, so the CPU data port (m0) and a bus-mastering DMA/video engine (m1) share the single a/d/we/rd/spo/ready/irq system bus.
- Each master sees an mmapper-style port.
- The arbiter sequences ownership with an FSM, round-robin or fixed priority.
- It forwards slave ready, data and irq to the owning master only.

Parameters:
FIXED_PRIO, 0, 0 = round-robin between m0/m1; 1 = m0 always wins ties
TIMEOUT, 1024, cycles an owned transaction may wait for s_ready (used only with ARB_TIMEOUT_EN)
CNT_W, 11, timeout counter width; must hold TIMEOUT

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
m0_a / m1_a  input  32  master address
m0_d / m1_d  input  32  master write data
m0_we / m1_we  input  1  write request, held until mX_ready
m0_rd / m1_rd  input  1  read request, held until mX_ready
m0_spo / m1_spo  output  32  read data to master
m0_ready / m1_ready  output  1  transfer complete / idle
m0_irq / m1_irq  output  1  bus address-fault to master
m0_err / m1_err  output  1  timeout abort (ARB_TIMEOUT_EN only, else 0)
s_a  output  32  bus address to mmapper
s_d  output  32  bus write data
s_we  output  1  bus write strobe
s_rd  output  1  bus read strobe
s_spo  input  32  bus read data
s_ready  input  1  bus ready from mmapper
s_irq  input  1  bus fault from mmapper
grant  output  2  owner status: 00 none, 01 m0, 10 m1

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- FSM states: IDLE, OWN0, OWN1. Register last_grant, which records the last owner.
- Reset values: state=IDLE, last_grant=m1 (so m0 wins the first tie), timeout counter=0, grant=00.
- While IDLE: s_a=0, s_d=0, s_we=0, s_rd=0, mX_spo=0, mX_irq=0, mX_err=0.
- A master is requesting when mX_rd|mX_we.
- mX_ready is 1 whenever master X is not requesting; this keeps the mmapper idle default.
- While X requests, mX_ready is 1 only in its completion cycle.
- IDLE transitions:
  - Only one master requesting: go to OWN of that master.
  - Both requesting: FIXED_PRIO=1 → OWN0; otherwise the master that is not last_grant.
  - This costs one arbitration cycle; no bus strobe is driven in IDLE.
- OWNx datapath: s_a/s_d/s_we/s_rd = mX_* combinationally. mX_spo=s_spo, mX_irq=s_irq, mX_ready=s_ready. The non-owner sees ready=0 while requesting, and spo=0.
- OWNx completion: when (mX_rd|mX_we) && s_ready, the transfer completes in that cycle. Update last_grant=X and go to IDLE.
  - The IDLE cycle after every transfer is mandatory. It prevents regranting on a stale held request.
  - Minimum cost is 2 cycles per transfer.
- Zero-wait slaves (uart, gpio with ready=1) complete in the first OWN cycle.
- Protocol violation: if the owner drops rd/we before ready, the FSM returns to IDLE next cycle. Strobes follow the master (0). last_grant is not updated.
- s_irq with s_ready=1 completes normally, with irq visible to the owner that cycle.
- rst asserted during OWN: state becomes IDLE at that edge and strobes go low. The in-flight transfer is dropped with no ready to the master.
- The non-owner's inputs never reach the bus. It keeps holding and is granted after the current transfer plus IDLE.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Enabled:
  - The counter clears on entry to OWNx and increments each OWN cycle without s_ready.
  - When the counter reaches TIMEOUT-1 without s_ready, that cycle forces mX_ready=1, mX_err=1, mX_spo=0.
  - s_rd/s_we are forced to 0 in that cycle.
  - Then go to IDLE with last_grant=X.
- Disabled: there is no counter, the FSM waits indefinitely, and mX_err is tied 0.

Decomposition:
- Shared package quasisoc_bus_pkg holds:
  - state encodings ST_IDLE/ST_OWN0/ST_OWN1;
  - grant encodings GNT_NONE/GNT_M0/GNT_M1;
  - default TIMEOUT.
- One natural sub-module: arb_rr2, the 2-requester round-robin/fixed-priority pick logic (inputs req[1:0], last_grant, FIXED_PRIO; output winner).

Test Plan:
- m0 reads 0x10000010 with s_ready=1 immediately → grant=01 at cycle 1. s_rd=1 and m0_ready=1 with m0_spo=s_spo at cycle 1. IDLE at cycle 2.
- Both request in the same cycle after reset, round-robin → m0 served first, then IDLE, then m1. Repeat → m1 first.
- FIXED_PRIO=1, both requesting continuously → m0 wins every arbitration; m1 never granted while m0 keeps requesting.
- m1 writes 0x94000000 while s_ready is held 0 for 5 cycles → s_we=1 for 6 cycles. m1_ready=1 only in cycle 6. m0's concurrent request sees ready=0 throughout.
- ARB_TIMEOUT_EN, TIMEOUT=8, s_ready stuck 0 → m0_err=1 and m0_ready=1 at the 8th OWN cycle, strobes low that cycle, then IDLE. Without the macro: waits indefinitely, err=0.
- rst pulsed in the 3rd OWN1 cycle of a stalled write → next cycle grant=00 and s_we=0. Reset mid-burst, then m0 request → m0 granted first.

Source files
------------

// File: rtl/quasisoc_bus_pkg.sv
// quasisoc_bus_pkg
// Shared definitions for the two-master system bus arbiter.
//   arb_state_t  : arbiter FSM states (idle, owned by m0, owned by m1)
//   master_t     : identifies one of the two bus masters
//   GNT_*        : encodings driven on the arbiter's grant status output
//   DEFAULT_*    : default stall timeout and the counter width that holds it
//   own_state()  : FSM state that corresponds to a master owning the bus
//   grant_code() : grant status encoding for a master owning the bus
package quasisoc_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_t;

    typedef enum logic {
        MST_M0 = 1'b0,
        MST_M1 = 1'b1
    } master_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    localparam int DEFAULT_TIMEOUT = 1024;
    localparam int DEFAULT_CNT_W   = 11;

    function automatic arb_state_t own_state(input master_t m);
        return (m == MST_M0) ? ST_OWN0 : ST_OWN1;
    endfunction

    function automatic logic [1:0] grant_code(input master_t m);
        return (m == MST_M0) ? GNT_M0 : GNT_M1;
    endfunction

endpackage

// File: rtl/arb_rr2.sv
// arb_rr2
// Two-requester pick logic used by the bus arbiter.
//   FIXED_PRIO : 0 = round-robin on ties, 1 = requester 0 always wins ties
//   req        : request vector, bit 0 = m0, bit 1 = m1
//   last_grant : master that completed the most recent transfer
//   winner     : master to grant; only meaningful while req is non-zero
module arb_rr2
    import quasisoc_bus_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic [1:0] req,
    input  master_t    last_grant,
    output master_t    winner
);

    // On a tie the round-robin policy hands the bus to whichever master
    // did not own it last, so neither can starve the other.
    always_comb begin
        winner = MST_M0;
        case (req)
            2'b01:   winner = MST_M0;
            2'b10:   winner = MST_M1;
            2'b11: begin
                if (FIXED_PRIO != 0) begin
                    winner = MST_M0;
                end else begin
                    winner = (last_grant == MST_M0) ? MST_M1 : MST_M0;
                end
            end
            default: winner = MST_M0;
        endcase
    end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter
// Two-master arbiter in front of mmapper: the CPU data port (m0) and a
// bus-mastering DMA/video engine (m1) share one a/d/we/rd/spo/ready/irq bus.
// Every transfer is followed by one mandatory IDLE cycle so that a request
// still held during its completion cycle is never regranted.
//
// Parameters
//   FIXED_PRIO : 0 = round-robin, 1 = m0 wins every tie
//   TIMEOUT    : cycles an owned transfer may wait for s_ready
//   CNT_W      : timeout counter width, must hold TIMEOUT
//
// Ports
//   clk, rst               : clock, synchronous active-high reset
//   mX_a, mX_d             : master address / write data
//   mX_we, mX_rd           : master write / read request, held until mX_ready
//   mX_spo                 : read data back to master (owner only)
//   mX_ready               : completion, or 1 while master X is not requesting
//   mX_irq                 : bus address fault (owner only)
//   mX_err                 : timeout abort (0 unless ARB_TIMEOUT_EN)
//   s_a, s_d, s_we, s_rd   : bus towards mmapper
//   s_spo, s_ready, s_irq  : bus response from mmapper
//   grant                  : 00 none, 01 m0, 10 m1
//
// Build option
//   ARB_TIMEOUT_EN : when defined, a transfer stalled for TIMEOUT cycles is
//                    aborted with mX_err=1; otherwise the arbiter waits forever.
module bus_arbiter
    import quasisoc_bus_pkg::*;
#(
    parameter int FIXED_PRIO = 0,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT,
    parameter int CNT_W      = DEFAULT_CNT_W
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] m0_a,
    input  logic [31:0] m0_d,
    input  logic        m0_we,
    input  logic        m0_rd,
    output logic [31:0] m0_spo,
    output logic        m0_ready,
    output logic        m0_irq,
    output logic        m0_err,

    input  logic [31:0] m1_a,
    input  logic [31:0] m1_d,
    input  logic        m1_we,
    input  logic        m1_rd,
    output logic [31:0] m1_spo,
    output logic        m1_ready,
    output logic        m1_irq,
    output logic        m1_err,

    output logic [31:0] s_a,
    output logic [31:0] s_d,
    output logic        s_we,
    output logic        s_rd,
    input  logic [31:0] s_spo,
    input  logic        s_ready,
    input  logic        s_irq,

    output logic [1:0]  grant
);

    // A counter too narrow for TIMEOUT would wrap before ever matching.
    generate
        if (TIMEOUT < 1 || CNT_W < $clog2(TIMEOUT + 1)) begin : g_bad_params
            $error("bus_arbiter: CNT_W too small for TIMEOUT");
        end
    endgenerate

    arb_state_t state;
    master_t    last_grant;
    master_t    winner;
    logic       m0_req;
    logic       m1_req;
    logic       timeout_hit;

    assign m0_req = m0_rd | m0_we;
    assign m1_req = m1_rd | m1_we;

    arb_rr2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_pick (
        .req        ({m1_req, m0_req}),
        .last_grant (last_grant),
        .winner     (winner)
    );

`ifdef ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             own_req;

    assign own_req = ((state == ST_OWN0) && m0_req) ||
                     ((state == ST_OWN1) && m1_req);

    // The counter sits at zero in IDLE, so it starts from zero in the first
    // OWN cycle and counts the cycles that ended without s_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state == ST_IDLE) begin
            wait_cnt <= '0;
        end else if (!s_ready) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign timeout_hit = own_req && !s_ready && (wait_cnt == CNT_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    // Ownership FSM. A transfer ends on s_ready, on a timeout abort, or when
    // the owner drops its request early; only the first two count as a
    // completed grant for round-robin purposes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_grant <= MST_M1;
            grant      <= GNT_NONE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (m0_req || m1_req) begin
                        state <= own_state(winner);
                        grant <= grant_code(winner);
                    end
                end
                ST_OWN0: begin
                    if (!m0_req) begin
                        state <= ST_IDLE;
                        grant <= GNT_NONE;
                    end else if (s_ready || timeout_hit) begin
                        state      <= ST_IDLE;
                        grant      <= GNT_NONE;
                        last_grant <= MST_M0;
                    end
                end
                ST_OWN1: begin
                    if (!m1_req) begin
                        state <= ST_IDLE;
                        grant <= GNT_NONE;
                    end else if (s_ready || timeout_hit) begin
                        state      <= ST_IDLE;
                        grant      <= GNT_NONE;
                        last_grant <= MST_M1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    grant <= GNT_NONE;
                end
            endcase
        end
    end

    // Bus datapath. A master that is not requesting always sees ready=1 so
    // it idles exactly as if it were wired straight to mmapper; a waiting
    // non-owner sees ready=0 and no data. On a timeout the strobes are
    // pulled low and the owner gets ready with err instead of read data.
    always_comb begin
        s_a      = '0;
        s_d      = '0;
        s_we     = 1'b0;
        s_rd     = 1'b0;
        m0_spo   = '0;
        m1_spo   = '0;
        m0_irq   = 1'b0;
        m1_irq   = 1'b0;
        m0_err   = 1'b0;
        m1_err   = 1'b0;
        m0_ready = !m0_req;
        m1_ready = !m1_req;
        case (state)
            ST_OWN0: begin
                s_a    = m0_a;
                s_d    = m0_d;
                s_we   = m0_we & ~timeout_hit;
                s_rd   = m0_rd & ~timeout_hit;
                m0_spo = timeout_hit ? 32'h0 : s_spo;
                m0_irq = s_irq;
                m0_err = timeout_hit;
                if (m0_req) begin
                    m0_ready = s_ready | timeout_hit;
                end
            end
            ST_OWN1: begin
                s_a    = m1_a;
                s_d    = m1_d;
                s_we   = m1_we & ~timeout_hit;
                s_rd   = m1_rd & ~timeout_hit;
                m1_spo = timeout_hit ? 32'h0 : s_spo;
                m1_irq = s_irq;
                m1_err = timeout_hit;
                if (m1_req) begin
                    m1_ready = s_ready | timeout_hit;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter
// Bench for bus_arbiter: a round-robin instance and a fixed-priority instance
// share the same master/slave stimulus. A directed vector table walks the
// arbitration, stall, reset and early-drop cases; a timeout sequence and a
// randomized run follow. Every cycle both instances are also compared with a
// transaction-level reference model of the arbitration rules.
module tb_bus_arbiter;

    localparam int TB_TIMEOUT = 8;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef struct packed {
        logic        rst;
        logic [31:0] m0_a;
        logic [31:0] m0_d;
        logic        m0_we;
        logic        m0_rd;
        logic [31:0] m1_a;
        logic [31:0] m1_d;
        logic        m1_we;
        logic        m1_rd;
        logic [31:0] s_spo;
        logic        s_ready;
        logic        s_irq;
    } ins_t;

    typedef struct packed {
        logic [1:0]  grant;
        logic [31:0] s_a;
        logic [31:0] s_d;
        logic        s_we;
        logic        s_rd;
        logic [31:0] m0_spo;
        logic [31:0] m1_spo;
        logic        m0_ready;
        logic        m1_ready;
        logic        m0_irq;
        logic        m1_irq;
        logic        m0_err;
        logic        m1_err;
    } outs_t;

    // owner: -1 = bus free, 0 = m0, 1 = m1; waited = stalled OWN cycles so far
    typedef struct {
        int owner;
        int last;
        int waited;
    } model_t;

    typedef struct {
        bit         rst;
        bit         m0_rd;
        bit         m0_we;
        bit         m1_rd;
        bit         m1_we;
        bit         s_ready;
        logic [1:0] exp_grant;
        bit         exp_s_rd;
        bit         exp_s_we;
        bit         exp_m0_ready;
        bit         exp_m1_ready;
        logic [1:0] exp_fp_grant;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m0_a, m0_d, m1_a, m1_d, s_spo;
    logic        m0_we, m0_rd, m1_we, m1_rd, s_ready, s_irq;

    logic [31:0] rr_m0_spo, rr_m1_spo, rr_s_a, rr_s_d;
    logic        rr_m0_ready, rr_m1_ready, rr_m0_irq, rr_m1_irq, rr_m0_err, rr_m1_err;
    logic        rr_s_we, rr_s_rd;
    logic [1:0]  rr_grant;

    logic [31:0] fp_m0_spo, fp_m1_spo, fp_s_a, fp_s_d;
    logic        fp_m0_ready, fp_m1_ready, fp_m0_irq, fp_m1_irq, fp_m0_err, fp_m1_err;
    logic        fp_s_we, fp_s_rd;
    logic [1:0]  fp_grant;

    int     n_checks = 0;
    int     n_fails  = 0;
    int     cycle    = 0;
    model_t mdl_rr   = '{owner: -1, last: 1, waited: 0};
    model_t mdl_fp   = '{owner: -1, last: 1, waited: 0};
    vec_t   tbl[$];

    always #5 clk = ~clk;

    bus_arbiter #(
        .FIXED_PRIO (0),
        .TIMEOUT    (TB_TIMEOUT),
        .CNT_W      (4)
    ) dut (
        .clk      (clk),      .rst      (rst),
        .m0_a     (m0_a),     .m0_d     (m0_d),     .m0_we    (m0_we),    .m0_rd    (m0_rd),
        .m0_spo   (rr_m0_spo), .m0_ready (rr_m0_ready), .m0_irq (rr_m0_irq), .m0_err (rr_m0_err),
        .m1_a     (m1_a),     .m1_d     (m1_d),     .m1_we    (m1_we),    .m1_rd    (m1_rd),
        .m1_spo   (rr_m1_spo), .m1_ready (rr_m1_ready), .m1_irq (rr_m1_irq), .m1_err (rr_m1_err),
        .s_a      (rr_s_a),   .s_d      (rr_s_d),   .s_we     (rr_s_we),  .s_rd     (rr_s_rd),
        .s_spo    (s_spo),    .s_ready  (s_ready),  .s_irq    (s_irq),
        .grant    (rr_grant)
    );

    bus_arbiter #(
        .FIXED_PRIO (1),
        .TIMEOUT    (TB_TIMEOUT),
        .CNT_W      (4)
    ) dut_fp (
        .clk      (clk),      .rst      (rst),
        .m0_a     (m0_a),     .m0_d     (m0_d),     .m0_we    (m0_we),    .m0_rd    (m0_rd),
        .m0_spo   (fp_m0_spo), .m0_ready (fp_m0_ready), .m0_irq (fp_m0_irq), .m0_err (fp_m0_err),
        .m1_a     (m1_a),     .m1_d     (m1_d),     .m1_we    (m1_we),    .m1_rd    (m1_rd),
        .m1_spo   (fp_m1_spo), .m1_ready (fp_m1_ready), .m1_irq (fp_m1_irq), .m1_err (fp_m1_err),
        .s_a      (fp_s_a),   .s_d      (fp_s_d),   .s_we     (fp_s_we),  .s_rd     (fp_s_rd),
        .s_spo    (s_spo),    .s_ready  (s_ready),  .s_irq    (s_irq),
        .grant    (fp_grant)
    );

    outs_t out_rr, out_fp;
    assign out_rr = '{rr_grant, rr_s_a, rr_s_d, rr_s_we, rr_s_rd, rr_m0_spo, rr_m1_spo,
                      rr_m0_ready, rr_m1_ready, rr_m0_irq, rr_m1_irq, rr_m0_err, rr_m1_err};
    assign out_fp = '{fp_grant, fp_s_a, fp_s_d, fp_s_we, fp_s_rd, fp_m0_spo, fp_m1_spo,
                      fp_m0_ready, fp_m1_ready, fp_m0_irq, fp_m1_irq, fp_m0_err, fp_m1_err};

    // Expected outputs for the current cycle, given who owns the bus.
    function automatic outs_t modelOut(model_t m, ins_t v);
        outs_t       o;
        bit          req[2];
        bit          rdy[2];
        bit          irq[2];
        bit          err[2];
        logic [31:0] spo[2];
        bit          to;
        int          k;
        o      = '0;
        req[0] = v.m0_rd | v.m0_we;
        req[1] = v.m1_rd | v.m1_we;
        rdy[0] = !req[0];
        rdy[1] = !req[1];
        irq    = '{0, 0};
        err    = '{0, 0};
        spo    = '{32'h0, 32'h0};
        k      = m.owner;
        if (k >= 0) begin
            to = TO_EN && req[k] && !v.s_ready && (m.waited == TB_TIMEOUT - 1);
            o.grant = (k == 0) ? 2'b01 : 2'b10;
            o.s_a   = (k == 0) ? v.m0_a : v.m1_a;
            o.s_d   = (k == 0) ? v.m0_d : v.m1_d;
            o.s_we  = !to && ((k == 0) ? v.m0_we : v.m1_we);
            o.s_rd  = !to && ((k == 0) ? v.m0_rd : v.m1_rd);
            spo[k]  = to ? 32'h0 : v.s_spo;
            irq[k]  = v.s_irq;
            err[k]  = to;
            if (req[k]) rdy[k] = v.s_ready || to;
        end
        o.m0_spo   = spo[0];
        o.m1_spo   = spo[1];
        o.m0_ready = rdy[0];
        o.m1_ready = rdy[1];
        o.m0_irq   = irq[0];
        o.m1_irq   = irq[1];
        o.m0_err   = err[0];
        o.m1_err   = err[1];
        return o;
    endfunction

    // Ownership after the clock edge.
    function automatic model_t modelNext(model_t m, ins_t v, bit fixed);
        model_t n;
        bit     req[2];
        n      = m;
        req[0] = v.m0_rd | v.m0_we;
        req[1] = v.m1_rd | v.m1_we;
        if (v.rst) begin
            n = '{owner: -1, last: 1, waited: 0};
        end else if (m.owner < 0) begin
            if (req[0] && req[1]) n.owner = fixed ? 0 : 1 - m.last;
            else if (req[0])      n.owner = 0;
            else if (req[1])      n.owner = 1;
            n.waited = 0;
        end else if (!req[m.owner]) begin
            n.owner = -1;
        end else if (v.s_ready ||
                     (TO_EN && m.waited == TB_TIMEOUT - 1)) begin
            n.last  = m.owner;
            n.owner = -1;
        end else begin
            n.waited = m.waited + 1;
        end
        return n;
    endfunction

    function automatic vec_t row(bit r, bit a0, bit b0, bit a1, bit b1, bit rdy,
                                 logic [1:0] g, bit srd, bit swe, bit r0, bit r1,
                                 logic [1:0] fg);
        vec_t x;
        x = '{r, a0, b0, a1, b1, rdy, g, srd, swe, r0, r1, fg};
        return x;
    endfunction

    function automatic ins_t baseIns();
        ins_t v;
        v       = '0;
        v.m0_a  = 32'h1000_0010;
        v.m0_d  = 32'h0000_00A5;
        v.m1_a  = 32'h9400_0000;
        v.m1_d  = 32'hCAFE_0001;
        v.s_spo = 32'h1234_5678;
        return v;
    endfunction

    // Drive one cycle of inputs after the active edge, then wait for the
    // falling edge where outputs are sampled.
    task automatic applyStimulus(input ins_t v);
        rst     = v.rst;
        m0_a    = v.m0_a;   m0_d  = v.m0_d;  m0_we = v.m0_we; m0_rd = v.m0_rd;
        m1_a    = v.m1_a;   m1_d  = v.m1_d;  m1_we = v.m1_we; m1_rd = v.m1_rd;
        s_spo   = v.s_spo;  s_ready = v.s_ready; s_irq = v.s_irq;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [137:0] act,
                               input logic [137:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cycle, act, exp);
        end
    endtask

    task automatic checkModels(input ins_t v);
        checkOutput("model_rr", out_rr, modelOut(mdl_rr, v));
        checkOutput("model_fp", out_fp, modelOut(mdl_fp, v));
    endtask

    task automatic stepModels(input ins_t v);
        @(posedge clk);
        #1;
        mdl_rr = modelNext(mdl_rr, v, 1'b0);
        mdl_fp = modelNext(mdl_fp, v, 1'b1);
        cycle++;
    endtask

    initial begin
        ins_t v;
        ins_t vr;

        // Columns: rst m0_rd m0_we m1_rd m1_we s_ready | grant s_rd s_we m0_ready m1_ready fp_grant
        tbl.push_back(row(0,0,0,0,0,0, 2'b00,0,0,1,1, 2'b00));  // reset state
        tbl.push_back(row(0,1,0,0,0,1, 2'b00,0,0,0,1, 2'b00));  // m0 read, arbitration cycle
        tbl.push_back(row(0,1,0,0,0,1, 2'b01,1,0,1,1, 2'b01));  // zero-wait completion
        tbl.push_back(row(0,0,0,0,0,1, 2'b00,0,0,1,1, 2'b00));
        tbl.push_back(row(1,0,0,0,0,0, 2'b00,0,0,1,1, 2'b00));  // reset restores last_grant=m1
        tbl.push_back(row(0,1,0,0,1,1, 2'b00,0,0,0,0, 2'b00));  // tie after reset
        tbl.push_back(row(0,1,0,0,1,1, 2'b01,1,0,1,0, 2'b01));  // m0 first
        tbl.push_back(row(0,0,0,0,1,1, 2'b00,0,0,1,0, 2'b00));
        tbl.push_back(row(0,0,0,0,1,1, 2'b10,0,1,1,1, 2'b10));  // then m1
        tbl.push_back(row(0,0,0,0,0,1, 2'b00,0,0,1,1, 2'b00));
        tbl.push_back(row(0,1,0,0,0,1, 2'b00,0,0,0,1, 2'b00));
        tbl.push_back(row(0,1,0,0,0,1, 2'b01,1,0,1,1, 2'b01));  // last_grant=m0
        tbl.push_back(row(0,1,0,0,1,1, 2'b00,0,0,0,0, 2'b00));  // tie: rr -> m1, fp -> m0
        tbl.push_back(row(0,1,0,0,1,1, 2'b10,0,1,0,1, 2'b01));
        tbl.push_back(row(0,1,0,0,1,1, 2'b00,0,0,0,0, 2'b00));
        tbl.push_back(row(0,1,0,0,1,1, 2'b01,1,0,1,0, 2'b01));
        tbl.push_back(row(0,1,0,0,1,1, 2'b00,0,0,0,0, 2'b00));
        tbl.push_back(row(0,1,0,0,1,1, 2'b10,0,1,0,1, 2'b01));
        tbl.push_back(row(0,0,0,0,0,1, 2'b00,0,0,1,1, 2'b00));
        tbl.push_back(row(0,0,0,0,1,0, 2'b00,0,0,1,0, 2'b00));  // m1 write, 5 wait states
        for (int i = 0; i < 5; i++)
            tbl.push_back(row(0,1,0,0,1,0, 2'b10,0,1,0,0, 2'b10));
        tbl.push_back(row(0,1,0,0,1,1, 2'b10,0,1,0,1, 2'b10));  // 6th strobe cycle completes
        tbl.push_back(row(0,1,0,0,0,1, 2'b00,0,0,0,1, 2'b00));
        tbl.push_back(row(0,1,0,0,0,1, 2'b01,1,0,1,1, 2'b01));
        tbl.push_back(row(0,0,0,0,0,0, 2'b00,0,0,1,1, 2'b00));
        tbl.push_back(row(0,0,0,0,1,0, 2'b00,0,0,1,0, 2'b00));  // stalled m1 write
        tbl.push_back(row(0,0,0,0,1,0, 2'b10,0,1,1,0, 2'b10));
        tbl.push_back(row(0,0,0,0,1,0, 2'b10,0,1,1,0, 2'b10));
        tbl.push_back(row(1,0,0,0,1,0, 2'b10,0,1,1,0, 2'b10));  // reset in 3rd OWN1 cycle
        tbl.push_back(row(0,1,0,0,1,0, 2'b00,0,0,0,0, 2'b00));  // dropped, no ready
        tbl.push_back(row(0,1,0,0,1,1, 2'b01,1,0,1,0, 2'b01));  // m0 granted first
        tbl.push_back(row(0,0,0,0,1,1, 2'b00,0,0,1,0, 2'b00));
        tbl.push_back(row(0,0,0,0,1,1, 2'b10,0,1,1,1, 2'b10));
        tbl.push_back(row(0,0,0,0,0,0, 2'b00,0,0,1,1, 2'b00));
        tbl.push_back(row(0,1,0,0,0,0, 2'b00,0,0,0,1, 2'b00));
        tbl.push_back(row(0,0,0,0,0,0, 2'b01,0,0,1,1, 2'b01));  // owner drops early
        tbl.push_back(row(0,1,0,0,1,0, 2'b00,0,0,0,0, 2'b00));  // last_grant still m1
        tbl.push_back(row(0,1,0,0,1,0, 2'b01,1,0,0,0, 2'b01));
        tbl.push_back(row(0,0,0,0,0,0, 2'b01,0,0,1,1, 2'b01));
        tbl.push_back(row(0,0,0,0,0,0, 2'b00,0,0,1,1, 2'b00));

        // Power-up reset; outputs are unknown until the first edge.
        v     = baseIns();
        v.rst = 1'b1;
        applyStimulus(v);
        stepModels(v);

        $display("[TB] directed vector table, %0d rows", tbl.size());
        for (int i = 0; i < tbl.size(); i++) begin
            v         = baseIns();
            v.rst     = tbl[i].rst;
            v.m0_rd   = tbl[i].m0_rd;
            v.m0_we   = tbl[i].m0_we;
            v.m1_rd   = tbl[i].m1_rd;
            v.m1_we   = tbl[i].m1_we;
            v.s_ready = tbl[i].s_ready;
            applyStimulus(v);
            checkOutput($sformatf("vec%0d", i),
                        138'({rr_grant, rr_s_rd, rr_s_we, rr_m0_ready, rr_m1_ready, fp_grant}),
                        138'({tbl[i].exp_grant, tbl[i].exp_s_rd, tbl[i].exp_s_we,
                              tbl[i].exp_m0_ready, tbl[i].exp_m1_ready, tbl[i].exp_fp_grant}));
            checkModels(v);
            stepModels(v);
        end

        // m0 read against a slave that never answers: aborted at the 8th OWN
        // cycle when the timeout is built in, still waiting otherwise.
        $display("[TB] stalled read, timeout enabled = %0d", TO_EN);
        v       = baseIns();
        v.m0_rd = 1'b1;
        for (int i = 0; i < 11; i++) begin
            applyStimulus(v);
            if (i == TB_TIMEOUT) begin
                checkOutput("timeout",
                            138'({rr_grant, rr_m0_err, rr_m0_ready, rr_s_rd, rr_m0_spo}),
                            TO_EN ? 138'({2'b01, 1'b1, 1'b1, 1'b0, 32'h0})
                                  : 138'({2'b01, 1'b0, 1'b0, 1'b1, 32'h1234_5678}));
            end
            checkModels(v);
            stepModels(v);
            if (i == TB_TIMEOUT) v.m0_rd = 1'b0;
        end

        $display("[TB] randomized run");
        for (int n = 0; n < 3000; n++) begin
            vr         = '0;
            vr.rst     = ($urandom_range(0, 63) == 0);
            vr.m0_a    = $urandom;
            vr.m0_d    = $urandom;
            vr.m0_rd   = ($urandom_range(0, 3) != 0);
            vr.m0_we   = ($urandom_range(0, 3) == 0);
            vr.m1_a    = $urandom;
            vr.m1_d    = $urandom;
            vr.m1_rd   = ($urandom_range(0, 3) == 0);
            vr.m1_we   = ($urandom_range(0, 3) != 0);
            vr.s_spo   = $urandom;
            vr.s_ready = ($urandom_range(0, 2) == 0);
            vr.s_irq   = ($urandom_range(0, 7) == 0);
            applyStimulus(vr);
            checkModels(vr);
            stepModels(vr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
